seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 3-digit seven-segment driver.
- Samples the scanned SevenSegment/Enable bus and waits for each digit strobe to settle.
- Decodes segment patterns back to hex nibbles and publishes a coherent 3-digit frame with a valid pulse.
- Used for loopback self-check of the display path and as a bench-side display monitor.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_pattern_decode.sv | 38 +++
 rtl/seg7_scan_decoder.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: hex segment patterns,
// segment bit positions and the scan FSM state encoding.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam int SEG_A_BIT  = 0;
   localparam int SEG_G_BIT  = 6;
   localparam int SEG_DP_BIT = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high 7-segment pattern back to its hex nibble, flagging the
// all-off pattern as blank and anything unrecognised as invalid.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] segments,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       invalid
);

   always_comb begin
      nibble  = 4'h0;
      blank   = 1'b0;
      invalid = 1'b0;
      case (segments)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed seven-segment bus, captures each digit once its strobe
// has settled, and publishes complete frames with a one-cycle valid pulse.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 3,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [7:0]              SevenSegment,
   input  logic [NUM_DIGITS-1:0]   Enable,
   output logic [4*NUM_DIGITS-1:0] Digits,
   output logic [NUM_DIGITS-1:0]   DecimalPoints,
   output logic [NUM_DIGITS-1:0]   Blank,
   output logic                    FrameValid,
   output logic                    PatternError,
   output logic                    Stale
);

   localparam int CNT_W = 8;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [7:0]              seg_p0, seg_p1;
   logic [NUM_DIGITS-1:0]   en_p0, en_p1;
   logic                    legal, changed, capture;
   scan_state_t             state, state_next;
   logic [CNT_W-1:0]        count, count_next;
   logic [3:0]              nibble;
   logic                    seg_blank, seg_invalid;
   logic [4*NUM_DIGITS-1:0] sh_digits;
   logic [NUM_DIGITS-1:0]   sh_dp, sh_blank, seen;
   logic [TMO_W-1:0]        tmo_cnt;
   logic                    frame_done, timeout;

   // p0: polarity-normalised bus; p1: previous cycle for stability compare
   always_ff @(posedge Clk) begin
      if (Reset) begin
         seg_p0 <= '0;
         en_p0  <= '0;
         seg_p1 <= '0;
         en_p1  <= '0;
      end else begin
         seg_p0 <= SEG_ACTIVE_LOW ? ~SevenSegment : SevenSegment;
         en_p0  <= EN_ACTIVE_LOW ? ~Enable : Enable;
         seg_p1 <= seg_p0;
         en_p1  <= en_p0;
      end
   end

   assign legal   = $onehot(en_p0);
   assign changed = ({en_p0, seg_p0} != {en_p1, seg_p1});

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // count_next is the number of cycles the current bus value has been seen
   always_comb begin
      state_next = state;
      count_next = count;
      if (!legal) begin
         state_next = IDLE;
         count_next = '0;
      end else if (state == HOLD && !changed) begin
         state_next = HOLD;
      end else begin
         count_next = (state == SETTLE && !changed) ? count + 1'b1 : CNT_W'(1);
         state_next = (count_next == CNT_W'(SETTLE_CYCLES)) ? HOLD : SETTLE;
      end
   end

   always_comb begin
      capture = 1'b0;
      if (legal && !(state == HOLD && !changed) && count_next == CNT_W'(SETTLE_CYCLES))
         capture = 1'b1;
   end

   seg7_pattern_decode u_decode (
      .segments (seg_p0[SEG_G_BIT:SEG_A_BIT]),
      .nibble   (nibble),
      .blank    (seg_blank),
      .invalid  (seg_invalid)
   );

   assign frame_done = &seen;
   assign timeout    = (seen != '0) && !capture && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // p2: shadow frame, publish and timeout bookkeeping
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sh_digits     <= '0;
         sh_dp         <= '0;
         sh_blank      <= '0;
         seen          <= '0;
         tmo_cnt       <= '0;
         Digits        <= '0;
         DecimalPoints <= '0;
         Blank         <= '0;
         FrameValid    <= 1'b0;
         PatternError  <= 1'b0;
         Stale         <= 1'b0;
      end else begin
         FrameValid <= frame_done;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && en_p0[i]) begin
               sh_digits[4*i +: 4] <= nibble;
               sh_dp[i]            <= seg_p0[SEG_DP_BIT];
               sh_blank[i]         <= seg_blank;
            end
         end
         if (capture && seg_invalid)
            PatternError <= 1'b1;
         if (frame_done) begin
            Digits        <= sh_digits;
            DecimalPoints <= sh_dp;
            Blank         <= sh_blank;
            Stale         <= 1'b0;
         end else if (timeout) begin
            Stale <= 1'b1;
         end
         // A capture coinciding with publish starts the next frame
         if (frame_done || timeout)
            seen <= capture ? en_p0 : '0;
         else if (capture)
            seen <= seen | en_p0;
         if (capture || seen == '0 || timeout)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table-driven frames with a scoreboard of
// expected published frames, plus glitch, illegal-enable, timeout and reset sequences.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [7:0]  SevenSegment;
   logic [2:0]  Enable;
   logic [11:0] Digits;
   logic [2:0]  DecimalPoints;
   logic [2:0]  Blank;
   logic        FrameValid;
   logic        PatternError;
   logic        Stale;

   seg7_scan_decoder #(
      .NUM_DIGITS     (3),
      .SETTLE_CYCLES  (4),
      .TIMEOUT_CYCLES (100),
      .SEG_ACTIVE_LOW (1'b1),
      .EN_ACTIVE_LOW  (1'b1)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .SevenSegment  (SevenSegment),
      .Enable        (Enable),
      .Digits        (Digits),
      .DecimalPoints (DecimalPoints),
      .Blank         (Blank),
      .FrameValid    (FrameValid),
      .PatternError  (PatternError),
      .Stale         (Stale)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [11:0] digits;
      logic [2:0]  dp;
      logic [2:0]  blank;
   } frame_t;

   typedef struct {
      logic [7:0] seg0;
      logic [7:0] seg1;
      logic [7:0] seg2;
      frame_t     exp;
      logic       perr;
   } vec_t;

   frame_t sb_q[$];
   frame_t mon_exp;
   vec_t   tbl[7];
   int     n_vec = 0;
   int     n_bad = 0;
   int     fv_count = 0;
   int     fv0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Hold one bus value for the given number of clock cycles
   task automatic drive(input logic [2:0] en, input logic [7:0] seg, input int cycles);
      @(negedge Clk);
      Enable       = en;
      SevenSegment = seg;
      repeat (cycles - 1) @(negedge Clk);
   endtask

   task automatic wait_frames();
      int n = 0;
      while (sb_q.size() != 0 && n < 30) begin
         @(negedge Clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("frame_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset && FrameValid) begin
         fv_count++;
         if (sb_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check("frame_digits", 32'(Digits), 32'(mon_exp.digits));
            check("frame_dp", 32'(DecimalPoints), 32'(mon_exp.dp));
            check("frame_blank", 32'(Blank), 32'(mon_exp.blank));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{8'hF9, 8'hA4, 8'hB0, '{12'h321, 3'b000, 3'b000}, 1'b0};
      tbl[1] = '{8'h88, 8'h03, 8'hC6, '{12'hCBA, 3'b010, 3'b000}, 1'b0};
      tbl[2] = '{8'hA1, 8'h86, 8'h8E, '{12'hFED, 3'b000, 3'b000}, 1'b0};
      tbl[3] = '{8'hC0, 8'h99, 8'h92, '{12'h540, 3'b000, 3'b000}, 1'b0};
      tbl[4] = '{8'hF8, 8'h80, 8'h90, '{12'h987, 3'b000, 3'b000}, 1'b0};
      tbl[5] = '{8'h02, 8'h82, 8'h82, '{12'h666, 3'b001, 3'b000}, 1'b0};
      tbl[6] = '{8'hB6, 8'hFF, 8'h00, '{12'h800, 3'b100, 3'b010}, 1'b1};

      Reset        = 1'b1;
      Enable       = 3'b111;
      SevenSegment = 8'hFF;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_digits", 32'(Digits), 32'd0);
      check("rst_dp", 32'(DecimalPoints), 32'd0);
      check("rst_blank", 32'(Blank), 32'd0);
      check("rst_fv", 32'(FrameValid), 32'd0);
      check("rst_perr", 32'(PatternError), 32'd0);
      check("rst_stale", 32'(Stale), 32'd0);

      for (int v = 0; v < 7; v++) begin
         sb_q.push_back(tbl[v].exp);
         drive(3'b110, tbl[v].seg0, 6);
         drive(3'b101, tbl[v].seg1, 6);
         drive(3'b011, tbl[v].seg2, 6);
         drive(3'b111, 8'hFF, 3);
         wait_frames();
         check("pattern_error", 32'(PatternError), 32'(tbl[v].perr));
      end

      // Glitch: digit 0 shows a wrong pattern for 2 cycles before settling on 1
      sb_q.push_back('{12'h321, 3'b000, 3'b000});
      drive(3'b101, 8'hA4, 6);
      drive(3'b011, 8'hB0, 6);
      drive(3'b110, 8'hC0, 2);
      @(negedge Clk);
      SevenSegment = 8'hF9;
      for (int k = 1; k <= 7; k++) begin
         @(negedge Clk);
         check("glitch_fv_timing", 32'(FrameValid), 32'(k == 6));
      end
      drive(3'b111, 8'hFF, 2);
      wait_frames();

      // Two digits selected at once must not capture
      sb_q.push_back('{12'h321, 3'b000, 3'b000});
      fv0 = fv_count;
      drive(3'b110, 8'hF9, 6);
      drive(3'b101, 8'hA4, 6);
      drive(3'b100, 8'hC0, 20);
      check("illegal_state_idle", 32'(dut.state), 32'(IDLE));
      check("illegal_no_frame", 32'(fv_count), 32'(fv0));
      drive(3'b011, 8'hB0, 6);
      drive(3'b111, 8'hFF, 3);
      wait_frames();

      // Partial frame abandoned past the timeout
      fv0 = fv_count;
      drive(3'b110, 8'hF9, 6);
      check("stale_before", 32'(Stale), 32'd0);
      drive(3'b111, 8'hFF, 105);
      check("stale_set", 32'(Stale), 32'd1);
      check("timeout_no_frame", 32'(fv_count), 32'(fv0));
      check("timeout_held_digits", 32'(Digits), 32'h321);
      sb_q.push_back('{12'h321, 3'b000, 3'b000});
      drive(3'b110, 8'hF9, 6);
      drive(3'b101, 8'hA4, 6);
      drive(3'b011, 8'hB0, 6);
      drive(3'b111, 8'hFF, 3);
      wait_frames();
      check("stale_cleared", 32'(Stale), 32'd0);

      // Reset between digits discards the partial frame
      fv0 = fv_count;
      drive(3'b110, 8'hF9, 6);
      drive(3'b101, 8'hA4, 6);
      @(negedge Clk);
      Reset        = 1'b1;
      Enable       = 3'b111;
      SevenSegment = 8'hFF;
      @(negedge Clk);
      Reset = 1'b0;
      drive(3'b011, 8'hB0, 6);
      drive(3'b111, 8'hFF, 10);
      check("mid_rst_no_frame", 32'(fv_count), 32'(fv0));
      check("mid_rst_digits", 32'(Digits), 32'd0);
      check("mid_rst_dp", 32'(DecimalPoints), 32'd0);
      check("mid_rst_blank", 32'(Blank), 32'd0);
      check("mid_rst_perr", 32'(PatternError), 32'd0);
      check("mid_rst_stale", 32'(Stale), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
